adc_pingpong_buf: RTL and testbench

ADC_PINGPONG_BUF -- requirements
Module: adc_pingpong_buf

---
 rtl/adc_buf_pkg.sv | 17 +
 rtl/dp_ram_sc.sv | 27 ++
 rtl/adc_pingpong_buf.sv | 172 +++++++++++++++++
 tb/tb_adc_pingpong_buf.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_buf_pkg.sv
// Shared definitions for the ADC ping-pong buffer: writer FSM encoding,
// overrun counter width and its saturating increment.
package adc_buf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_STALL = 2'd2
  } wr_state_e;

  localparam int OVR_W = 16;

  function automatic logic [OVR_W-1:0] sat_inc(input logic [OVR_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/dp_ram_sc.sv
// Simple dual-port single-clock RAM: one write port, one registered read port.
module dp_ram_sc #(
  parameter int DW = 16,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];

  // NOTE: the array itself has no reset so it maps onto block RAM; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (rst) rdata_o <= '0;
    else     rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/adc_pingpong_buf.sv
// Ping-pong capture buffer: serializes ADC frames into two banks and offers
// each full bank to a USB reader, counting frames dropped on overrun.
module adc_pingpong_buf
  import adc_buf_pkg::*;
#(
  parameter  int CH_NUM = 2,
  parameter  int DW     = 16,
  parameter  int DEPTH  = 2048,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 adc_wren,
  input  logic [CH_NUM*DW-1:0] adc_data,
  input  logic [AW-1:0]        usb_rdaddr,
  output logic [DW-1:0]        usb_rddata,
  output logic                 send_go,
  output logic                 send_bank,
  input  logic                 usb_done,
  input  logic                 ovr_clr,
  output logic                 overrun,
  output logic [OVR_W-1:0]     ovr_cnt
);

  localparam int CW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

  wr_state_e              state_q, state_d;
  logic                   wbank_q, wbank_d;
  logic [AW-1:0]          wptr_q, wptr_d;
  logic [CW-1:0]          ch_q, ch_d;
  logic [CH_NUM*DW-1:0]   frame_q, frame_d;
  logic [1:0]             full_q, full_d, full_rel;
  logic                   offered_q, offered_d, offered_rel;
  logic                   send_bank_q, send_bank_d;
  logic                   send_go_q, send_go_d;
  logic                   overrun_q, overrun_d;
  logic [OVR_W-1:0]       ovr_cnt_q, ovr_cnt_d;
  logic                   ram_we, drop, fill;

  // A release by the reader is applied first so a bank fill or stall
  // decision in the same cycle already sees the freed bank.
  always_comb begin
    full_rel    = full_q;
    offered_rel = offered_q;
    if (usb_done && offered_q) begin
      full_rel[send_bank_q] = 1'b0;
      offered_rel           = 1'b0;
    end
  end

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    wbank_d = wbank_q;
    wptr_d  = wptr_q;
    ch_d    = ch_q;
    frame_d = frame_q;
    ram_we  = 1'b0;
    drop    = 1'b0;
    fill    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (adc_wren) begin
          frame_d = adc_data;
          ch_d    = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        drop    = adc_wren;
        ram_we  = 1'b1;
        frame_d = frame_q >> DW;
        if (ch_q == CW'(CH_NUM - 1)) begin
          ch_d    = '0;
          state_d = ST_IDLE;
        end else begin
          ch_d = ch_q + 1'b1;
        end
        if (wptr_q == AW'(DEPTH - 1)) begin
          fill    = 1'b1;
          wbank_d = ~wbank_q;
          wptr_d  = '0;
          if (full_rel[~wbank_q]) state_d = ST_STALL;
        end else begin
          wptr_d = wptr_q + 1'b1;
        end
      end
      ST_STALL: begin
        drop = adc_wren;
        if (!full_rel[wbank_q]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Offer a full bank whenever none is outstanding, preferring the bank
  // after the one last offered so the reader alternates.
  always_comb begin
    full_d = full_rel;
    if (fill) full_d[wbank_q] = 1'b1;
    offered_d   = offered_rel;
    send_bank_d = send_bank_q;
    send_go_d   = 1'b0;
    if (!offered_rel && (full_d != 2'b00)) begin
      send_bank_d = full_d[~send_bank_q] ? ~send_bank_q : send_bank_q;
      offered_d   = 1'b1;
      send_go_d   = 1'b1;
    end
  end

  // A clear coinciding with a drop leaves exactly that one drop recorded.
  always_comb begin
    overrun_d = overrun_q;
    ovr_cnt_d = ovr_cnt_q;
    if (ovr_clr) begin
      overrun_d = drop;
      ovr_cnt_d = {{(OVR_W-1){1'b0}}, drop};
    end else if (drop) begin
      overrun_d = 1'b1;
      ovr_cnt_d = sat_inc(ovr_cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wbank_q     <= 1'b0;
      wptr_q      <= '0;
      ch_q        <= '0;
      full_q      <= 2'b00;
      offered_q   <= 1'b0;
      send_bank_q <= 1'b0;
      send_go_q   <= 1'b0;
      overrun_q   <= 1'b0;
      ovr_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      wbank_q     <= wbank_d;
      wptr_q      <= wptr_d;
      ch_q        <= ch_d;
      full_q      <= full_d;
      offered_q   <= offered_d;
      send_bank_q <= send_bank_d;
      send_go_q   <= send_go_d;
      overrun_q   <= overrun_d;
      ovr_cnt_q   <= ovr_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    frame_q <= frame_d;
  end

  dp_ram_sc #(
    .DW (DW),
    .AW (AW + 1)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (ram_we),
    .waddr_i ({wbank_q, wptr_q}),
    .wdata_i (frame_q[DW-1:0]),
    .raddr_i ({send_bank_q, usb_rdaddr}),
    .rdata_o (usb_rddata)
  );

  assign send_go   = send_go_q;
  assign send_bank = send_bank_q;
  assign overrun   = overrun_q;
  assign ovr_cnt   = ovr_cnt_q;

endmodule

// File: tb/tb_adc_pingpong_buf.sv
// Self-checking bench for adc_pingpong_buf: directed scenarios with literal
// expectations plus random traffic, all compared to a bank-level model.
module tb_adc_pingpong_buf;

  localparam int CH_NUM = 2;
  localparam int DW     = 16;
  localparam int DEPTH  = 16;
  localparam int AW     = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 adc_wren;
  logic [CH_NUM*DW-1:0] adc_data;
  logic [AW-1:0]        usb_rdaddr;
  logic [DW-1:0]        usb_rddata;
  logic                 send_go;
  logic                 send_bank;
  logic                 usb_done;
  logic                 ovr_clr;
  logic                 overrun;
  logic [15:0]          ovr_cnt;

  always #5 clk = ~clk;

  adc_pingpong_buf #(.CH_NUM(CH_NUM), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .adc_wren   (adc_wren),
    .adc_data   (adc_data),
    .usb_rdaddr (usb_rdaddr),
    .usb_rddata (usb_rddata),
    .send_go    (send_go),
    .send_bank  (send_bank),
    .usb_done   (usb_done),
    .ovr_clr    (ovr_clr),
    .overrun    (overrun),
    .ovr_cnt    (ovr_cnt)
  );

  int total = 0;
  int bad   = 0;
  int go_seen = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Model: two banks as plain arrays, a count of channels still to write,
  // full flags per bank and which bank the reader currently holds.
  logic [DW-1:0] m_mem   [2][DEPTH];
  bit            m_wr_ok [2][DEPTH];
  logic [DW-1:0] m_frame [CH_NUM];
  int            m_left, m_wb, m_wp, m_sb;
  bit            m_stall, m_off;
  bit [1:0]      m_full;
  bit            e_go, e_ovr, e_rd_ok;
  int            e_cnt;
  logic [DW-1:0] e_rd;
  bit            live = 1'b0;

  always @(posedge clk) begin : model
    bit       drop;
    bit [1:0] f;
    if (rst) begin
      m_left = 0; m_wb = 0; m_wp = 0; m_sb = 0;
      m_stall = 1'b0; m_off = 1'b0; m_full = 2'b00;
      e_go = 1'b0; e_ovr = 1'b0; e_cnt = 0; e_rd = '0; e_rd_ok = 1'b1;
      live = 1'b1;
    end else begin
      e_rd_ok = m_wr_ok[m_sb][usb_rdaddr];
      e_rd    = m_mem[m_sb][usb_rdaddr];
      f    = m_full;
      drop = 1'b0;
      if (usb_done && m_off) begin
        f[m_sb] = 1'b0;
        m_off   = 1'b0;
      end
      if (m_stall) begin
        drop = adc_wren;
        if (!f[m_wb]) m_stall = 1'b0;
      end else if (m_left > 0) begin
        drop = adc_wren;
        m_mem[m_wb][m_wp]   = m_frame[CH_NUM - m_left];
        m_wr_ok[m_wb][m_wp] = 1'b1;
        m_left--;
        if (m_wp == DEPTH - 1) begin
          f[m_wb] = 1'b1;
          m_wb    = 1 - m_wb;
          m_wp    = 0;
          if (f[m_wb]) m_stall = 1'b1;
        end else begin
          m_wp++;
        end
      end else if (adc_wren) begin
        for (int c = 0; c < CH_NUM; c++) m_frame[c] = adc_data[c*DW +: DW];
        m_left = CH_NUM;
      end
      if (ovr_clr) begin
        e_ovr = drop;
        e_cnt = drop ? 1 : 0;
      end else if (drop) begin
        e_ovr = 1'b1;
        if (e_cnt < 65535) e_cnt++;
      end
      e_go = 1'b0;
      if (!m_off && f != 2'b00) begin
        if (f[1 - m_sb]) m_sb = 1 - m_sb;
        m_off = 1'b1;
        e_go  = 1'b1;
      end
      m_full = f;
    end
  end

  always @(negedge clk) begin
    if (live) begin
      check("send_go", send_go, e_go);
      check("send_bank", send_bank, m_sb);
      check("overrun", overrun, e_ovr);
      check("ovr_cnt", ovr_cnt, e_cnt);
      if (e_rd_ok) check("usb_rddata", usb_rddata, e_rd);
      if (send_go === 1'b1) go_seen++;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame(input int a, input int b);
    adc_wren = 1'b1;
    adc_data = {DW'(b), DW'(a)};
    tick();
    adc_wren = 1'b0;
    tick(3);
  endtask

  task automatic pulse_done();
    usb_done = 1'b1;
    tick();
    usb_done = 1'b0;
  endtask

  task automatic pulse_clr();
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic read_bank(input string name, input int base0, input int base1);
    for (int i = 0; i < DEPTH; i++) begin
      usb_rdaddr = AW'(i);
      tick();
      check(name, usb_rddata, (i % 2) ? base1 + i / 2 : base0 + i / 2);
    end
  endtask

  initial begin
    int g0;
    rst = 1'b1; adc_wren = 1'b0; adc_data = '0; usb_rdaddr = '0;
    usb_done = 1'b0; ovr_clr = 1'b0;
    tick(2);
    check("rst send_go", send_go, 0);
    check("rst send_bank", send_bank, 0);
    check("rst overrun", overrun, 0);
    check("rst ovr_cnt", ovr_cnt, 0);
    check("rst rddata", usb_rddata, 0);
    rst = 1'b0;

    // First bank fills and is offered once.
    g0 = go_seen;
    for (int n = 0; n < 8; n++) frame(n, n + 100);
    check("s1 go count", go_seen - g0, 1);
    check("s1 bank", send_bank, 0);
    read_bank("s1 rd", 0, 100);

    // Second bank fills while the first is held; offered only after release.
    g0 = go_seen;
    for (int n = 0; n < 8; n++) frame(n + 200, n + 300);
    tick(4);
    check("s2 go held", go_seen - g0, 0);
    check("s2 bank held", send_bank, 0);
    pulse_done();
    tick();
    check("s2 go after done", go_seen - g0, 1);
    check("s2 bank after done", send_bank, 1);
    read_bank("s2 rd", 200, 300);
    pulse_done();
    tick(2);

    // Back-to-back strobes drop the second frame; clear with a coincident drop.
    adc_wren = 1'b1; adc_data = 32'h0001_0002; tick();
    adc_data = 32'h0003_0004; tick();
    adc_wren = 1'b0; tick(3);
    check("s3 overrun", overrun, 1);
    check("s3 ovr_cnt", ovr_cnt, 1);
    adc_wren = 1'b1; tick(2); adc_wren = 1'b0; tick(3);
    check("s3 ovr_cnt 2", ovr_cnt, 2);
    adc_wren = 1'b1; tick();
    ovr_clr = 1'b1; tick();
    adc_wren = 1'b0; ovr_clr = 1'b0; tick(3);
    check("s3 clr+drop cnt", ovr_cnt, 1);
    check("s3 clr+drop ovr", overrun, 1);
    pulse_clr();
    check("s3 clr overrun", overrun, 0);
    check("s3 clr ovr_cnt", ovr_cnt, 0);

    // Both banks full: frames dropped, nothing written; resume at bank 0 address 0.
    do_reset();
    for (int n = 0; n < 16; n++) frame(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
    for (int n = 0; n < 5; n++) frame(16'hDEAD, 16'hBEEF);
    check("s4 ovr_cnt", ovr_cnt, 5);
    check("s4 overrun", overrun, 1);
    pulse_done();
    tick();
    check("s4 bank after done", send_bank, 1);
    frame(16'hAAAA, 16'hBBBB);
    pulse_done();
    for (int n = 0; n < 7; n++) frame(n, n);
    check("s4 bank0 offered", send_bank, 0);
    usb_rdaddr = 4'd0; tick();
    check("s4 addr0", usb_rddata, 16'hAAAA);
    usb_rdaddr = 4'd1; tick();
    check("s4 addr1", usb_rddata, 16'hBBBB);

    // Saturation of the drop counter while stalled.
    for (int n = 0; n < 8; n++) frame(n, n);
    adc_wren = 1'b1;
    tick(65540);
    adc_wren = 1'b0;
    tick();
    check("s4 ovr_cnt sat", ovr_cnt, 16'hFFFF);
    pulse_clr();
    check("s4 sat cleared", ovr_cnt, 0);
    pulse_done();
    tick(2);
    pulse_done();
    tick(2);

    // Fill of bank 1 in the same cycle as release of bank 0.
    do_reset();
    for (int n = 0; n < 8; n++) frame(n, n);
    for (int n = 0; n < 7; n++) frame(n + 1, n + 2);
    g0 = go_seen;
    adc_wren = 1'b1; adc_data = 32'h1234_5678; tick();
    adc_wren = 1'b0; tick();
    usb_done = 1'b1; tick();
    usb_done = 1'b0; tick(4);
    check("s5 single go", go_seen - g0, 1);
    check("s5 bank", send_bank, 1);

    // Reset mid-fill discards partial data.
    do_reset();
    for (int n = 0; n < 3; n++) frame(n + 900, n + 950);
    do_reset();
    g0 = go_seen;
    tick(5);
    check("s6 no go after rst", go_seen - g0, 0);
    for (int n = 0; n < 8; n++) frame(n + 40, n + 70);
    check("s6 go count", go_seen - g0, 1);
    check("s6 bank", send_bank, 0);
    read_bank("s6 rd", 40, 70);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      adc_wren   = ($urandom_range(0, 2) == 0);
      adc_data   = 32'($urandom);
      usb_done   = ($urandom_range(0, 15) == 0);
      ovr_clr    = ($urandom_range(0, 39) == 0);
      usb_rdaddr = AW'($urandom_range(0, DEPTH - 1));
      tick();
    end
    adc_wren = 1'b0; usb_done = 1'b0; ovr_clr = 1'b0;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
